// File: rtl/host_reg_slave_if.sv
// rtl/host_reg_slave_if.sv - host register bus: strobe, direction, address, write and read data
interface host_reg_slave_if;
    logic       sel;
    logic       wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output sel, output wr, output addr, output wdata, input rdata);
    modport slave  (input sel, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/host_reg_slave.sv
// rtl/host_reg_slave.sv - 16-entry host register file with ID, scratch, ctrl, counter and byte FIFO
module host_reg_slave #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] ID_VALUE   = 8'hA5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    host_reg_slave_if.slave  bus,
    output logic             irq_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    localparam logic [3:0] A_ID      = 4'h0;
    localparam logic [3:0] A_SCRATCH = 4'h1;
    localparam logic [3:0] A_CTRL    = 4'h2;
    localparam logic [3:0] A_COUNT   = 4'h3;
    localparam logic [3:0] A_FDATA   = 4'h4;
    localparam logic [3:0] A_FSTAT   = 4'h5;

    logic [7:0]       scratch_q;
    logic             cnt_en_q;
    logic [7:0]       count_q;
    logic [7:0]       rdata_q;
    logic             irq_q;
    logic             ovf_q;
    logic             udf_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [7:0]       mem [FIFO_DEPTH];

    logic       rd_en;
    logic       wr_en;
    logic       fifo_empty;
    logic       fifo_full;
    logic       push;
    logic       pop;
    logic       ovf_set;
    logic       udf_set;
    logic       fifo_clr;
    logic [7:0] stat;
    logic [7:0] rd_val;

    assign rd_en      = bus.sel & ~bus.wr;
    assign wr_en      = bus.sel &  bus.wr;
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LVL);

    // Only one access per cycle, so push and pop never coincide.
    assign push     = wr_en && (bus.addr == A_FDATA) && !fifo_full;
    assign pop      = rd_en && (bus.addr == A_FDATA) && !fifo_empty;
    assign ovf_set  = wr_en && (bus.addr == A_FDATA) &&  fifo_full;
    assign udf_set  = rd_en && (bus.addr == A_FDATA) &&  fifo_empty;
    assign fifo_clr = wr_en && (bus.addr == A_CTRL) && bus.wdata[1];

    assign stat = {udf_q, ovf_q, fifo_full, fifo_empty, 4'(level_q)};

    always_comb begin
        rd_val = 8'h00;
        case (bus.addr)
            A_ID:      rd_val = ID_VALUE;
            A_SCRATCH: rd_val = scratch_q;
            A_CTRL:    rd_val = {7'd0, cnt_en_q};
            A_COUNT:   rd_val = count_q;
            A_FDATA:   rd_val = fifo_empty ? 8'h00 : mem[rd_ptr_q];
            A_FSTAT:   rd_val = stat;
            default:   rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q   <= 8'h00;
            irq_q     <= 1'b0;
            scratch_q <= 8'h00;
            cnt_en_q  <= 1'b0;
            count_q   <= 8'h00;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            if (rd_en) begin
                rdata_q <= rd_val;
            end
            irq_q <= ovf_q | udf_q;

            if (wr_en && bus.addr == A_SCRATCH) begin
                scratch_q <= bus.wdata;
            end
            if (wr_en && bus.addr == A_CTRL) begin
                cnt_en_q <= bus.wdata[0];
            end

            // A host write to COUNT takes priority over the running increment.
            if (wr_en && bus.addr == A_COUNT) begin
                count_q <= bus.wdata;
            end else if (cnt_en_q) begin
                count_q <= count_q + 8'd1;
            end

            if (fifo_clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                level_q  <= level_q + LVL_W'(1);
            end else if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                level_q  <= level_q - LVL_W'(1);
            end

            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_en && bus.addr == A_FSTAT && bus.wdata[6]) begin
                ovf_q <= 1'b0;
            end
            if (udf_set) begin
                udf_q <= 1'b1;
            end else if (wr_en && bus.addr == A_FSTAT && bus.wdata[7]) begin
                udf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.wdata;
        end
    end

    assign bus.rdata = rdata_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_host_reg_slave.sv
// tb/tb_host_reg_slave.sv - directed and randomized checks of host_reg_slave against a queue-based model
module tb_host_reg_slave;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic irq_o;

    host_reg_slave_if bus ();

    host_reg_slave #(.FIFO_DEPTH(8), .ID_VALUE(8'hA5)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus),
        .irq_o  (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] m_scratch;
    logic       m_cnt_en;
    logic [7:0] m_count;
    logic [7:0] m_rdata;
    logic       m_ovf;
    logic       m_udf;
    logic       m_irq;
    logic [7:0] m_fifo [$];

    task automatic model_reset();
        m_scratch = 8'h00;
        m_cnt_en  = 1'b0;
        m_count   = 8'h00;
        m_rdata   = 8'h00;
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
        m_irq     = 1'b0;
        m_fifo.delete();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One bus cycle: the model computes the expected outcome from pre-edge state,
    // then rdata and irq are compared one time unit after the edge.
    task automatic access(input logic s, input logic w, input logic [3:0] a, input logic [7:0] d);
        logic       next_irq;
        logic [7:0] next_count;
        int         lvl;
        bus.sel   = s;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        next_irq   = m_ovf | m_udf;
        next_count = (s && w && a == 4'h3) ? d : (m_cnt_en ? m_count + 8'd1 : m_count);
        lvl = m_fifo.size();
        if (s && !w) begin
            case (a)
                4'h0: m_rdata = 8'hA5;
                4'h1: m_rdata = m_scratch;
                4'h2: m_rdata = {7'd0, m_cnt_en};
                4'h3: m_rdata = m_count;
                4'h4: begin
                    if (lvl == 0) begin
                        m_rdata = 8'h00;
                        m_udf   = 1'b1;
                    end else begin
                        m_rdata = m_fifo.pop_front();
                    end
                end
                4'h5: m_rdata = {m_udf, m_ovf, lvl == 8, lvl == 0, 4'(lvl)};
                default: m_rdata = 8'h00;
            endcase
        end else if (s && w) begin
            case (a)
                4'h1: m_scratch = d;
                4'h2: begin
                    m_cnt_en = d[0];
                    if (d[1]) m_fifo.delete();
                end
                4'h4: begin
                    if (lvl == 8) m_ovf = 1'b1;
                    else          m_fifo.push_back(d);
                end
                4'h5: begin
                    if (d[6]) m_ovf = 1'b0;
                    if (d[7]) m_udf = 1'b0;
                end
                default: ;
            endcase
        end
        m_count = next_count;
        m_irq   = next_irq;
        @(posedge clk_i);
        #1;
        check($sformatf("rdata s=%0b w=%0b a=%h", s, w, a), bus.rdata, m_rdata);
        check("irq", {7'd0, irq_o}, {7'd0, m_irq});
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        access(1'b1, 1'b1, a, d);
    endtask

    task automatic rd_reg(input logic [3:0] a);
        access(1'b1, 1'b0, a, 8'h00);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        logic [3:0] ra;
        bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 4'h0; bus.wdata = 8'h00;
        model_reset();
        #1;
        check("reset_rdata", bus.rdata, 8'h00);
        check("reset_irq", {7'd0, irq_o}, 8'h00);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        rd_reg(4'h0);  check("id", bus.rdata, 8'hA5);
        rd_reg(4'h1);  check("scratch_rst", bus.rdata, 8'h00);
        wr_reg(4'h1, 8'h3C);
        rd_reg(4'h1);  check("scratch_rw", bus.rdata, 8'h3C);
        rd_reg(4'h9);  check("reserved", bus.rdata, 8'h00);
        idle();        check("rdata_hold", bus.rdata, 8'h00);

        wr_reg(4'h3, 8'hFE);
        wr_reg(4'h2, 8'h01);
        rd_reg(4'h3);  check("cnt0", bus.rdata, 8'hFE);
        rd_reg(4'h3);  check("cnt1", bus.rdata, 8'hFF);
        rd_reg(4'h3);  check("cnt_wrap", bus.rdata, 8'h00);
        rd_reg(4'h3);  check("cnt3", bus.rdata, 8'h01);
        wr_reg(4'h3, 8'h10);
        idle();
        idle();
        rd_reg(4'h3);  check("cnt_load", bus.rdata, 8'h12);
        wr_reg(4'h2, 8'h00);

        for (int i = 0; i < 8; i++) wr_reg(4'h4, 8'h11 + 8'(i));
        rd_reg(4'h5);  check("stat_full", bus.rdata, 8'h28);
        wr_reg(4'h4, 8'h99);
        rd_reg(4'h5);  check("stat_ovf", bus.rdata, 8'h68);
        check("irq_ovf", {7'd0, irq_o}, 8'h01);
        for (int i = 0; i < 8; i++) begin
            rd_reg(4'h4);
            check("pop_order", bus.rdata, 8'h11 + 8'(i));
        end
        rd_reg(4'h4);  check("pop_empty", bus.rdata, 8'h00);
        rd_reg(4'h5);  check("stat_udf", bus.rdata, 8'hD0);
        wr_reg(4'h5, 8'hC0);
        rd_reg(4'h5);  check("stat_w1c", bus.rdata, 8'h10);
        check("irq_clear", {7'd0, irq_o}, 8'h00);

        for (int i = 0; i < 3; i++) wr_reg(4'h4, 8'h40 + 8'(i));
        wr_reg(4'h2, 8'h02);
        rd_reg(4'h5);  check("fifo_clr", bus.rdata, 8'h10);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ra = 4'h4;
                4, 5:       ra = 4'h5;
                6:          ra = 4'h2;
                default:    ra = 4'($urandom_range(0, 15));
            endcase
            access($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), ra, 8'($urandom));
        end

        wr_reg(4'h1, 8'h5A);
        wr_reg(4'h2, 8'h01);
        wr_reg(4'h4, 8'h77);
        rd_reg(4'h4);
        rd_reg(4'h4);
        rd_reg(4'h0);
        check("irq_pre_reset", {7'd0, irq_o}, 8'h01);
        bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = 4'h1;
        #3;
        rst_ni = 1'b0;
        #1;
        check("async_rst_rdata", bus.rdata, 8'h00);
        check("async_rst_irq", {7'd0, irq_o}, 8'h00);
        model_reset();
        bus.sel = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        rd_reg(4'h1);  check("rst_scratch", bus.rdata, 8'h00);
        rd_reg(4'h2);  check("rst_ctrl", bus.rdata, 8'h00);
        rd_reg(4'h3);  check("rst_count", bus.rdata, 8'h00);
        rd_reg(4'h5);  check("rst_stat", bus.rdata, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/host_reg_slave.md
# host_reg_slave

Register-file responder for the host bus: the target end of the `sel`/`wr`/`addr`/`wdata`/`rdata` protocol driven by the host agent. It decodes single-cycle host accesses into a 16-entry, 8-bit address space. The space holds an ID register, a scratch register, a control register, a free-running counter, and an 8-deep byte FIFO with status. It sits in the DUT directly behind the host bus pins and provides a sticky error interrupt to the rest of the design.

## Interface
- `FIFO_DEPTH`, 8: FIFO entries. Legal values are 2, 4 or 8.
- `ID_VALUE`, 8'hA5: constant returned at address 0x0.

Ports:
- `clk_i`  in  1  clock. All state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `sel`  in  1  access strobe. One access per cycle in which it is high.
- `wr`  in  1  1 = write, 0 = read. Qualified by `sel`.
- `addr`  in  4  register address.
- `wdata`  in  8  write data. Qualified by `sel & wr`.
- `rdata`  out  8  registered read data.
- `irq_o`  out  1  registered. Equals `ovf | udf`.

## Operation
- An access is sampled at each rising edge of `clk_i` where `sel` = 1. Accesses may occur back-to-back every cycle. There is no wait state and no error response.
- Register map:
  - 0x0 ID: read-only, returns `ID_VALUE`. Writes are ignored.
  - 0x1 SCRATCH: read/write, reset value 0x00.
  - 0x2 CTRL:
    - Bit 0 is `cnt_en` (read/write, reset 0).
    - Bit 1 is `fifo_clr`, write-1 pulse. It empties the FIFO (pointers and level set to 0) and does not clear the sticky bits. It reads as 0.
    - Bits 7:2 read as 0.
  - 0x3 COUNT: 8-bit counter, reset value 0x00.
    - Increments by 1 every cycle while `cnt_en` = 1 and wraps from 0xFF to 0x00.
    - A write loads `wdata`. A write in the same cycle as an increment wins: COUNT equals `wdata` after the edge.
  - 0x4 FIFO_DATA: a write pushes `wdata` and a read pops the head.
    - Push while full: data dropped, `ovf` set.
    - Pop while empty: `rdata` = 0x00, `udf` set, pointers unchanged.
  - 0x5 FIFO_STAT bit fields:
    - [3:0] level, 0..`FIFO_DEPTH`, zero-extended.
    - [4] empty.
    - [5] full.
    - [6] `ovf`.
    - [7] `udf`.
  - 0x5 FIFO_STAT write behaviour: writing 1 to bit 6 or bit 7 clears that bit (W1C). All other bits are read-only.
  - Sticky set versus W1C clear in the same cycle cannot happen, because they use different addresses.
  - 0x6–0xF: reserved. Reads return 0x00 and writes are ignored.
- FIFO pointers are binary and wrap modulo `FIFO_DEPTH`. The level counter is ⌈log2(`FIFO_DEPTH`)⌉+1 bits wide.

## Timing
- Reset (asynchronous, immediate, including mid-access):
  - `rdata` = 0x00 and `irq_o` = 0.
  - SCRATCH = 0, CTRL = 0, COUNT = 0.
  - FIFO empty, `ovf` = 0, `udf` = 0.
- Write: takes effect at the sampling edge E. A read of the same address sampled at E+1 returns the new value.
- Read: at edge E, `rdata` is loaded with the register value as it was before E (pre-edge state). `rdata` is stable from just after E until the next read. The driver samples it at E+1, so read latency is 1 cycle.
- `rdata` holds its last value through write cycles and idle cycles.
- COUNT read returns the pre-increment value at E.
- FIFO_DATA pop at E: `rdata` = head entry. The level decrements, and the new level is visible to a FIFO_STAT read at E+1.
- `irq_o` updates one edge after `ovf`/`udf` change.

## Test plan
- Reset, then read 0x0 and 0x1 → `rdata` = 0xA5, then 0x00. `irq_o` = 0 throughout.
- Write 0x3C to 0x1, then read 0x1 on the very next cycle → `rdata` = 0x3C one cycle after the read. Read of 0x9 → 0x00.
- Write 0xFE to 0x3, then write 0x01 to 0x2 → COUNT runs 0xFF, 0x00, 0x01 on successive cycles (wrap). Write 0x10 to 0x3 while counting → the next read returns 0x10 plus the elapsed cycles.
- Push 0x11..0x18 (8 writes to 0x4), then read 0x5 → 0x28 (level 8, full). A 9th push of 0x99 → 0x5 reads 0x68 and `irq_o` = 1. Eight pops then return 0x11..0x18 in order.
- Pop while empty → `rdata` = 0x00 and `udf` set. Write 0xC0 to 0x5 → status reads 0x10 and `irq_o` drops one cycle later.
- With 3 entries queued, write 0x02 to 0x2 → 0x5 reads 0x10. Assert `rst_ni` low mid-burst → all outputs and registers return to reset values immediately.
